// File: rtl/cache_fill_fsm.sv
// Cache miss fill initiator: issues one read per block word, writes the in-order
// responses into the data array, then writes the tag and pulses fill_done.
module cache_fill_fsm #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8,
  parameter int MEM_LATENCY = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           miss_detected,
  input  logic [ADDR_WIDTH-1:0]          miss_address,
  output logic                           fsm_busy,
  output logic                           memory_enable,
  output logic [ADDR_WIDTH-1:0]          memory_address,
  input  logic                           memory_data_valid,
  input  logic [15:0]                    memory_data_in,
  output logic                           write_data_array,
  output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_offset,
  output logic [15:0]                    cache_data_out,
  output logic                           write_tag_array,
  output logic                           fill_done
);

  localparam int OFFW = $clog2(BLOCK_WORDS);
  localparam int CNTW = OFFW + 1;
  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  // Memory latency is only a property of the attached memory; the FSM tracks
  // responses by count, so the parameter is checked but never counted.
  if ((BLOCK_WORDS < 2) || ((BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0) || (MEM_LATENCY < 1)) begin : g_bad_params
    $error("cache_fill_fsm: BLOCK_WORDS must be a power of two >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CNTW-1:0]       r_issue_cnt;
  logic [OFFW-1:0]       r_recv_cnt;
  logic                  w_issue_pending;
  logic                  w_last_word;

  assign w_issue_pending = (r_issue_cnt < CNTW'(BLOCK_WORDS));
  assign w_last_word     = (r_recv_cnt == OFFW'(BLOCK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_base      <= '0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (r_state == IDLE) begin
      if (miss_detected) begin
        r_base      <= miss_address & BLK_MASK;
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end
    end else begin
      if (w_issue_pending)   r_issue_cnt <= r_issue_cnt + 1'b1;
      if (memory_data_valid) r_recv_cnt  <= r_recv_cnt + 1'b1;
    end
  end

  always_comb begin
    w_next_state      = r_state;
    fsm_busy          = 1'b0;
    memory_enable     = 1'b0;
    memory_address    = '0;
    write_data_array  = 1'b0;
    cache_word_offset = '0;
    cache_data_out    = '0;
    write_tag_array   = 1'b0;
    fill_done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (miss_detected) w_next_state = FILL;
      end
      FILL: begin
        fsm_busy = 1'b1;
        if (w_issue_pending) begin
          memory_enable  = 1'b1;
          memory_address = r_base + (ADDR_WIDTH'(r_issue_cnt) << 1);
        end
        if (memory_data_valid) begin
          write_data_array  = 1'b1;
          cache_word_offset = r_recv_cnt;
          cache_data_out    = memory_data_in;
          if (w_last_word) begin
            write_tag_array = 1'b1;
            fill_done       = 1'b1;
            w_next_state    = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed bench for cache_fill_fsm with a latency-4 pipelined memory that
// returns data equal to the requested address.
module tb_cache_fill_fsm;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        fsm_busy, memory_enable, write_data_array, write_tag_array, fill_done;
  logic [15:0] memory_address, cache_data_out;
  logic        memory_data_valid;
  logic [15:0] memory_data_in;
  logic [2:0]  cache_word_offset;

  logic           force_valid = 1'b0;
  logic [15:0]    force_data = '0;
  logic [LAT-1:0] pv = '0;
  logic [15:0]    pd [LAT];

  int checks = 0;
  int errors = 0;

  cache_fill_fsm #(.ADDR_WIDTH(16), .BLOCK_WORDS(8), .MEM_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .fsm_busy(fsm_busy), .memory_enable(memory_enable), .memory_address(memory_address),
    .memory_data_valid(memory_data_valid), .memory_data_in(memory_data_in),
    .write_data_array(write_data_array), .cache_word_offset(cache_word_offset),
    .cache_data_out(cache_data_out), .write_tag_array(write_tag_array), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  // Memory model: a request seen at edge c is answered during cycle c+LAT.
  initial for (int i = 0; i < LAT; i++) pd[i] = '0;
  always @(posedge clk) begin
    pv <= {pv[LAT-2:0], memory_enable};
    pd[0] <= memory_address;
    for (int i = 1; i < LAT; i++) pd[i] <= pd[i-1];
  end
  assign memory_data_valid = pv[LAT-1] | force_valid;
  assign memory_data_in    = force_valid ? force_data : pd[LAT-1];

  task automatic start_miss(input logic [15:0] addr);
    @(negedge clk);
    miss_detected = 1'b1;
    miss_address  = addr;
    @(negedge clk);
    miss_detected = 1'b0;
  endtask

  task automatic test_reset();
    logic [39:0] obs;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    obs = {fsm_busy, memory_enable, memory_address, write_data_array, cache_word_offset,
           cache_data_out, write_tag_array, fill_done};
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h, expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (fsm_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b, expected 0", fsm_busy);
    end
  endtask

  task automatic test_basic();
    logic [15:0] base, exp_addr, exp_data;
    logic        exp_en, exp_wr, exp_end, exp_busy;
    logic [2:0]  exp_off;
    base = 16'h1230;
    start_miss(16'h1236);
    for (int cyc = 1; cyc <= 13; cyc++) begin
      exp_en   = (cyc <= 8);
      exp_addr = exp_en ? base + 16'(2 * (cyc - 1)) : 16'h0000;
      exp_wr   = (cyc >= 5) && (cyc <= 12);
      exp_off  = exp_wr ? 3'(cyc - 5) : 3'd0;
      exp_data = exp_wr ? base + 16'(2 * (cyc - 5)) : 16'h0000;
      exp_end  = (cyc == 12);
      exp_busy = (cyc <= 12);
      checks += 8;
      if (memory_enable !== exp_en) begin
        errors++; $display("FAIL basic_en c%0d: got %b, expected %b", cyc, memory_enable, exp_en);
      end
      if (memory_address !== exp_addr) begin
        errors++; $display("FAIL basic_addr c%0d: got %h, expected %h", cyc, memory_address, exp_addr);
      end
      if (write_data_array !== exp_wr) begin
        errors++; $display("FAIL basic_wr c%0d: got %b, expected %b", cyc, write_data_array, exp_wr);
      end
      if (cache_word_offset !== exp_off) begin
        errors++; $display("FAIL basic_off c%0d: got %0d, expected %0d", cyc, cache_word_offset, exp_off);
      end
      if (cache_data_out !== exp_data) begin
        errors++; $display("FAIL basic_data c%0d: got %h, expected %h", cyc, cache_data_out, exp_data);
      end
      if (write_tag_array !== exp_end) begin
        errors++; $display("FAIL basic_tag c%0d: got %b, expected %b", cyc, write_tag_array, exp_end);
      end
      if (fill_done !== exp_end) begin
        errors++; $display("FAIL basic_done c%0d: got %b, expected %b", cyc, fill_done, exp_end);
      end
      if (fsm_busy !== exp_busy) begin
        errors++; $display("FAIL basic_busy c%0d: got %b, expected %b", cyc, fsm_busy, exp_busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_top_of_memory();
    int n_req = 0, n_wr = 0, n_tag = 0;
    start_miss(16'hFFFF);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (memory_enable === 1'b1) begin
        checks++;
        if (memory_address !== 16'hFFF0 + 16'(2 * n_req)) begin
          errors++;
          $display("FAIL top_addr req%0d: got %h, expected %h", n_req, memory_address, 16'hFFF0 + 16'(2 * n_req));
        end
        n_req++;
      end
      if (write_data_array === 1'b1) n_wr++;
      if (write_tag_array === 1'b1) n_tag++;
      @(negedge clk);
    end
    checks += 3;
    if (n_req != 8) begin errors++; $display("FAIL top_req_count: got %0d, expected 8", n_req); end
    if (n_wr != 8)  begin errors++; $display("FAIL top_wr_count: got %0d, expected 8", n_wr); end
    if (n_tag != 1) begin errors++; $display("FAIL top_tag_count: got %0d, expected 1", n_tag); end
  endtask

  task automatic test_reset_midfill();
    logic [39:0] obs;
    int late_valids = 0, bad_wr = 0, n_wr = 0, n_tag = 0;
    start_miss(16'h3000);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    obs = {fsm_busy, memory_enable, memory_address, write_data_array, cache_word_offset,
           cache_data_out, write_tag_array, fill_done};
    checks++;
    if (obs !== '0) begin
      errors++; $display("FAIL midreset_outputs: got %h, expected 0", obs);
    end
    for (int cyc = 7; cyc <= 12; cyc++) begin
      if (memory_data_valid === 1'b1) late_valids++;
      if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || fill_done !== 1'b0) bad_wr++;
      @(negedge clk);
    end
    checks += 2;
    if (late_valids != 4) begin
      errors++; $display("FAIL midreset_late_valids: got %0d, expected 4", late_valids);
    end
    if (bad_wr != 0) begin
      errors++; $display("FAIL midreset_writes_in_idle: got %0d, expected 0", bad_wr);
    end
    start_miss(16'h3456);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (write_data_array === 1'b1) begin
        checks++;
        if (cache_word_offset !== 3'(n_wr) || cache_data_out !== 16'h3450 + 16'(2 * n_wr)) begin
          errors++;
          $display("FAIL refill_write%0d: got off %0d data %h, expected off %0d data %h",
                   n_wr, cache_word_offset, cache_data_out, n_wr, 16'h3450 + 16'(2 * n_wr));
        end
        n_wr++;
      end
      if (write_tag_array === 1'b1) n_tag++;
      @(negedge clk);
    end
    checks += 2;
    if (n_wr != 8)  begin errors++; $display("FAIL refill_wr_count: got %0d, expected 8", n_wr); end
    if (n_tag != 1) begin errors++; $display("FAIL refill_tag_count: got %0d, expected 1", n_tag); end
  endtask

  task automatic test_miss_while_busy();
    int bad_addr = 0, n_done = 0;
    start_miss(16'h2000);
    miss_address = 16'h4000;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (memory_enable === 1'b1 && (memory_address & 16'hFFF0) !== 16'h2000) bad_addr++;
      if (fill_done === 1'b1) n_done++;
      miss_detected = (cyc <= 10) ? cyc[0] : 1'b0;
      @(negedge clk);
    end
    miss_detected = 1'b0;
    checks += 3;
    if (bad_addr != 0) begin errors++; $display("FAIL busy_foreign_addr: got %0d, expected 0", bad_addr); end
    if (n_done != 1)   begin errors++; $display("FAIL busy_done_count: got %0d, expected 1", n_done); end
    if (fsm_busy !== 1'b0) begin errors++; $display("FAIL busy_end_idle: got %b, expected 0", fsm_busy); end
  endtask

  task automatic test_spurious_valid();
    int bad = 0;
    @(negedge clk);
    force_valid = 1'b1;
    force_data  = 16'hBEEF;
    for (int cyc = 0; cyc < 2; cyc++) begin
      if (write_data_array !== 1'b0 || write_tag_array !== 1'b0 || cache_data_out !== 16'h0000 ||
          cache_word_offset !== 3'd0 || fsm_busy !== 1'b0) bad++;
      @(negedge clk);
    end
    force_valid = 1'b0;
    checks += 2;
    if (bad != 0) begin errors++; $display("FAIL spurious_write: got %0d bad cycles, expected 0", bad); end
    if (fsm_busy !== 1'b0) begin errors++; $display("FAIL spurious_state: got busy %b, expected 0", fsm_busy); end
  endtask

  task automatic test_back_to_back();
    int done_cyc = -1, second_cyc = -1, n_wr = 0, n_tag = 0, first_off = -1;
    start_miss(16'h0010);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (write_data_array === 1'b1) begin
        if (first_off < 0) first_off = int'(cache_word_offset);
        n_wr++;
      end
      if (write_tag_array === 1'b1) n_tag++;
      if (fill_done === 1'b1 && done_cyc < 0) done_cyc = cyc;
      if (memory_enable === 1'b1 && memory_address === 16'h0020 && second_cyc < 0) second_cyc = cyc;
      miss_address  = 16'h0020;
      miss_detected = (done_cyc >= 0) && (cyc == done_cyc + 1);
      @(negedge clk);
    end
    miss_detected = 1'b0;
    checks += 5;
    if (done_cyc != 12) begin errors++; $display("FAIL b2b_first_done: got cycle %0d, expected 12", done_cyc); end
    if (second_cyc != done_cyc + 2) begin
      errors++; $display("FAIL b2b_second_req: got cycle %0d, expected %0d", second_cyc, done_cyc + 2);
    end
    if (n_wr != 16) begin errors++; $display("FAIL b2b_wr_count: got %0d, expected 16", n_wr); end
    if (n_tag != 2) begin errors++; $display("FAIL b2b_tag_count: got %0d, expected 2", n_tag); end
    if (first_off != 0) begin errors++; $display("FAIL b2b_first_offset: got %0d, expected 0", first_off); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_top_of_memory();
    test_reset_midfill();
    test_miss_while_busy();
    test_spurious_valid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
